// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : X-Makina fetch stage. Owns the PC, fetches 16-bit words over
//                a req/ack handshake and feeds the decoder's instruction
//                register. Define FETCH_TIMEOUT_EN to enable the bus timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] inst_data,
    output logic        inst_valid,
    output logic [15:0] inst_pc,
    output logic [15:0] pc,
    output logic        busy,
    output logic        fetch_fault
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_wait  = 2'd1;
    localparam logic [1:0]  c_st_fault = 2'd2;
    localparam logic [15:0] c_reset_pc = RESET_PC & 16'hFFFE;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_pc;
    logic [15:0] r_mem_addr;
    logic        r_mem_req;
    logic [15:0] r_inst_data;
    logic [15:0] r_inst_pc;
    logic        r_inst_valid;
    logic        r_redirect_pending;
    logic [15:0] r_redirect_target;
    logic [15:0] w_load_addr;
    logic        w_timeout;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

`ifdef FETCH_TIMEOUT_EN
    localparam int              c_cnt_w        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_timeout_cnt;
    logic               r_fault;

    assign w_timeout = (r_state == c_st_wait) && !mem_ack && (r_timeout_cnt == c_timeout_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout_cnt <= '0;
            r_fault       <= 1'b0;
        end else begin
            if (r_state == c_st_idle && fetch_start) begin
                r_timeout_cnt <= '0;
            end else if (r_state == c_st_wait && !mem_ack) begin
                r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end else if (r_state == c_st_fault && pc_load) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign fetch_fault = r_fault;
`else
    assign w_timeout   = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign w_load_addr = pc_load_val & 16'hFFFE;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (fetch_start) w_state_next = c_st_wait;
            c_st_wait: begin
                if (mem_ack)        w_state_next = c_st_idle;
                else if (w_timeout) w_state_next = c_st_fault;
            end
            c_st_fault: if (pc_load) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc               <= c_reset_pc;
            r_mem_addr         <= 16'h0000;
            r_mem_req          <= 1'b0;
            r_inst_data        <= 16'h0000;
            r_inst_pc          <= 16'h0000;
            r_inst_valid       <= 1'b0;
            r_redirect_pending <= 1'b0;
            r_redirect_target  <= 16'h0000;
        end else begin
            r_inst_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (pc_load) r_pc <= w_load_addr;
                    if (fetch_start) begin
                        r_mem_addr         <= pc_load ? w_load_addr : r_pc;
                        r_mem_req          <= 1'b1;
                        r_redirect_pending <= 1'b0;
                    end
                end
                c_st_wait: begin
                    if (mem_ack) begin
                        r_mem_req          <= 1'b0;
                        r_redirect_pending <= 1'b0;
                        // A redirect arriving with the ack is the latest one and wins.
                        if (pc_load) begin
                            r_pc <= w_load_addr;
                        end else if (r_redirect_pending) begin
                            r_pc <= r_redirect_target;
                        end else begin
                            r_inst_data  <= mem_rdata;
                            r_inst_pc    <= r_mem_addr;
                            r_pc         <= r_mem_addr + 16'd2;
                            r_inst_valid <= 1'b1;
                        end
                    end else begin
                        if (pc_load) begin
                            r_redirect_pending <= 1'b1;
                            r_redirect_target  <= w_load_addr;
                        end
                        if (w_timeout) begin
                            r_mem_req          <= 1'b0;
                            r_redirect_pending <= 1'b0;
                        end
                    end
                end
                c_st_fault: begin
                    if (pc_load) r_pc <= w_load_addr;
                end
                default: r_mem_req <= 1'b0;
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign inst_data  = r_inst_data;
    assign inst_valid = r_inst_valid;
    assign inst_pc    = r_inst_pc;
    assign pc         = r_pc;
    assign busy       = (r_state == c_st_wait);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Directed vector bench for instruction_fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] inst_data;
    logic        inst_valid;
    logic [15:0] inst_pc;
    logic [15:0] pc;
    logic        busy;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        fs;
        logic        ld;
        logic [15:0] ldv;
        logic        ack;
        logic [15:0] rd;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_val;
        logic [15:0] e_data;
        logic [15:0] e_ipc;
        logic [15:0] e_pc;
    } vec_t;

    localparam int c_nvec = 21;
    vec_t vecs [c_nvec];

    instruction_fetch_unit #(
        .RESET_PC       (16'h0100),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_data   (inst_data),
        .inst_valid  (inst_valid),
        .inst_pc     (inst_pc),
        .pc          (pc),
        .busy        (busy),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fs, input logic ld, input logic [15:0] ldv,
                         input logic ack, input logic [15:0] rd);
        fetch_start = fs;
        pc_load     = ld;
        pc_load_val = ldv;
        mem_ack     = ack;
        mem_rdata   = rd;
    endtask

    function automatic vec_t mk(input logic fs, input logic ld, input logic [15:0] ldv,
                                input logic ack, input logic [15:0] rd,
                                input logic req, input logic [15:0] addr, input logic val,
                                input logic [15:0] data, input logic [15:0] ipc,
                                input logic [15:0] epc);
        vec_t v;
        v.fs = fs; v.ld = ld; v.ldv = ldv; v.ack = ack; v.rd = rd;
        v.e_req = req; v.e_addr = addr; v.e_val = val;
        v.e_data = data; v.e_ipc = ipc; v.e_pc = epc;
        return v;
    endfunction

    initial begin
        //              fs ld ldv       ack rd        req addr      val data      ipc       pc
        vecs[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000, 16'h0100);
        vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h4254, 0, 16'h0100, 1, 16'h4254, 16'h0100, 16'h0102);
        vecs[2]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0100, 0, 16'h4254, 16'h0100, 16'h0102);
        vecs[3]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0102, 0, 16'h4254, 16'h0100, 16'h0102);
        vecs[4]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0102, 0, 16'h4254, 16'h0100, 16'h0102);
        vecs[5]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0102, 0, 16'h4254, 16'h0100, 16'h0102);
        vecs[6]  = mk(0, 0, 16'h0000, 1, 16'h1FFE, 0, 16'h0102, 1, 16'h1FFE, 16'h0102, 16'h0104);
        vecs[7]  = mk(1, 1, 16'h0A05, 0, 16'h0000, 1, 16'h0A04, 0, 16'h1FFE, 16'h0102, 16'h0A04);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0A04, 1, 16'h1234, 16'h0A04, 16'h0A06);
        vecs[9]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0A06, 0, 16'h1234, 16'h0A04, 16'h0A06);
        vecs[10] = mk(0, 1, 16'h2000, 0, 16'h0000, 1, 16'h0A06, 0, 16'h1234, 16'h0A04, 16'h0A06);
        vecs[11] = mk(0, 0, 16'h0000, 1, 16'hDF1D, 0, 16'h0A06, 0, 16'h1234, 16'h0A04, 16'h2000);
        vecs[12] = mk(0, 0, 16'h0000, 1, 16'hBEEF, 0, 16'h0A06, 0, 16'h1234, 16'h0A04, 16'h2000);
        vecs[13] = mk(0, 1, 16'hFFFF, 0, 16'h0000, 0, 16'h0A06, 0, 16'h1234, 16'h0A04, 16'hFFFE);
        vecs[14] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 0, 16'h1234, 16'h0A04, 16'hFFFE);
        vecs[15] = mk(0, 0, 16'h0000, 1, 16'h0042, 0, 16'hFFFE, 1, 16'h0042, 16'hFFFE, 16'h0000);
        vecs[16] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0042, 16'hFFFE, 16'h0000);
        vecs[17] = mk(0, 1, 16'h3000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0042, 16'hFFFE, 16'h0000);
        vecs[18] = mk(0, 1, 16'h4001, 1, 16'hAAAA, 0, 16'h0000, 0, 16'h0042, 16'hFFFE, 16'h4000);
        vecs[19] = mk(1, 0, 16'h0000, 1, 16'h9999, 1, 16'h4000, 0, 16'h0042, 16'hFFFE, 16'h4000);
        vecs[20] = mk(1, 0, 16'h0000, 1, 16'h5555, 0, 16'h4000, 1, 16'h5555, 16'h4000, 16'h4002);

        reset = 1'b0;
        drive(0, 0, 16'h0000, 0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",    pc,                  16'h0100);
        check("rst_req",   {15'd0, mem_req},    16'h0000);
        check("rst_addr",  mem_addr,            16'h0000);
        check("rst_data",  inst_data,           16'h0000);
        check("rst_valid", {15'd0, inst_valid}, 16'h0000);
        check("rst_busy",  {15'd0, busy},       16'h0000);
        check("rst_fault", {15'd0, fetch_fault},16'h0000);
        @(negedge clk);
        reset = 1'b1;
        step();

        for (int i = 0; i < c_nvec; i++) begin
            drive(vecs[i].fs, vecs[i].ld, vecs[i].ldv, vecs[i].ack, vecs[i].rd);
            step();
            check($sformatf("v%0d_req", i),   {15'd0, mem_req},    {15'd0, vecs[i].e_req});
            check($sformatf("v%0d_busy", i),  {15'd0, busy},       {15'd0, vecs[i].e_req});
            check($sformatf("v%0d_addr", i),  mem_addr,            vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), {15'd0, inst_valid}, {15'd0, vecs[i].e_val});
            check($sformatf("v%0d_data", i),  inst_data,           vecs[i].e_data);
            check($sformatf("v%0d_ipc", i),   inst_pc,             vecs[i].e_ipc);
            check($sformatf("v%0d_pc", i),    pc,                  vecs[i].e_pc);
        end

        // Reset in the middle of a fetch, then a stale ack after release.
        drive(1, 0, 16'h0000, 0, 16'h0000);
        step();
        check("mid_req_before", {15'd0, mem_req}, 16'h0001);
        drive(0, 0, 16'h0000, 0, 16'h0000);
        #2;
        reset = 1'b0;
        #1;
        check("mid_req_async", {15'd0, mem_req}, 16'h0000);
        check("mid_busy",      {15'd0, busy},    16'h0000);
        check("mid_pc",        pc,               16'h0100);
        check("mid_data",      inst_data,        16'h0000);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 16'h0000, 1, 16'h7777);
        step();
        check("late_ack_valid", {15'd0, inst_valid}, 16'h0000);
        check("late_ack_data",  inst_data,           16'h0000);
        check("late_ack_req",   {15'd0, mem_req},    16'h0000);
        drive(0, 0, 16'h0000, 0, 16'h0000);
        step();
        check("late_ack_valid2", {15'd0, inst_valid}, 16'h0000);

`ifdef FETCH_TIMEOUT_EN
        drive(1, 0, 16'h0000, 0, 16'h0000);
        step();
        drive(0, 0, 16'h0000, 0, 16'h0000);
        repeat (15) step();
        check("to_fault_early", {15'd0, fetch_fault}, 16'h0000);
        check("to_req_early",   {15'd0, mem_req},     16'h0001);
        step();
        check("to_fault",       {15'd0, fetch_fault}, 16'h0001);
        check("to_req",         {15'd0, mem_req},     16'h0000);
        check("to_busy",        {15'd0, busy},        16'h0000);
        drive(0, 1, 16'h0000, 0, 16'h0000);
        step();
        check("to_clear",       {15'd0, fetch_fault}, 16'h0000);
        check("to_pc",          pc,                   16'h0000);
        drive(1, 0, 16'h0000, 0, 16'h0000);
        step();
        check("to_refetch",     {15'd0, mem_req},     16'h0001);
        drive(0, 0, 16'h0000, 0, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
